// File: rtl/rx_frame_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rx_ctrl_pkg
// Brief  : Mode and state encodings shared by the receive frame sequencer and
//          the depacketizer.
// Rev    : 1.0
//------------------------------------------------------------------------------
package rx_ctrl_pkg;

  localparam logic [3:0] MODE_NONE = 4'b0000;
  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  typedef enum logic [2:0] {
    STATE_IDLE  = 3'd0,
    STATE_PASS  = 3'd1,
    STATE_ARM   = 3'd2,
    STATE_SYNC  = 3'd3,
    STATE_RECV  = 3'd4,
    STATE_FLUSH = 3'd5
  } state_t;

  function automatic logic is_pass_mode(input logic [3:0] mode);
    return (mode == MODE_BPSK) || (mode == MODE_QPSK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rx_frame_ctrl_if
// Brief  : Detector, depacketizer-control and statistics signals of the
//          receive frame sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
interface rx_frame_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic [3:0]           cfg_mode;
  logic                 SD_flag;
  logic                 PD_flag;
  logic                 BD_flag;
  logic                 pkt_last;
  logic [3:0]           MODE_CTRL;
  logic                 dpkt_rst;
  logic                 clr_det;
  logic                 busy;
  logic [2:0]           state_o;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0] sync_err_cnt;
  logic [CNT_WIDTH-1:0] rx_err_cnt;
  logic                 err_pulse;

  modport master (
    input  enable, cfg_mode, SD_flag, PD_flag, BD_flag, pkt_last,
    output MODE_CTRL, dpkt_rst, clr_det, busy, state_o,
           frame_cnt, sync_err_cnt, rx_err_cnt, err_pulse
  );

  modport slave (
    output enable, cfg_mode, SD_flag, PD_flag, BD_flag, pkt_last,
    input  MODE_CTRL, dpkt_rst, clr_det, busy, state_o,
           frame_cnt, sync_err_cnt, rx_err_cnt, err_pulse
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_ctrl_watchdog.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rx_watchdog
// Brief  : Clearable cycle counter with a terminal-count compare against a
//          runtime-selected limit.
// Rev    : 1.0
//------------------------------------------------------------------------------
module rx_watchdog #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_tc
);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  // i_limit is the last permitted count, so the pulse marks the final cycle.
  assign o_tc = i_en && !i_clr && (r_cnt == i_limit);

endmodule
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rx_frame_ctrl
// Brief  : Receive frame sequencer arming the depacketizer after detection,
//          with sync/receive watchdogs, post-frame flush and statistics.
// Rev    : 1.0
//------------------------------------------------------------------------------
module rx_frame_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 1024,
  parameter int RX_TIMEOUT   = 16'hFFFF,
  parameter int FLUSH_CC     = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rx_frame_ctrl_if.master bus
);
  localparam int WD_MAX = (SYNC_TIMEOUT > RX_TIMEOUT) ? SYNC_TIMEOUT : RX_TIMEOUT;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam int FC_W   = $clog2(FLUSH_CC);

  localparam logic [WD_W-1:0]      c_sync_last  = WD_W'(SYNC_TIMEOUT - 1);
  localparam logic [WD_W-1:0]      c_rx_last    = WD_W'(RX_TIMEOUT - 1);
  localparam logic [FC_W-1:0]      c_flush_last = FC_W'(FLUSH_CC - 1);
  localparam logic [FC_W-1:0]      c_flush_one  = FC_W'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one    = CNT_WIDTH'(1);

  state_t               r_state;
  logic [3:0]           r_cfg;
  logic [3:0]           r_mode_ctrl;
  logic                 r_dpkt_rst;
  logic                 r_clr_det;
  logic                 r_busy;
  logic                 r_err_pulse;
  logic [FC_W-1:0]      r_flush_cnt;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic [CNT_WIDTH-1:0] r_sync_err_cnt;
  logic [CNT_WIDTH-1:0] r_rx_err_cnt;

  logic            w_abort;
  logic            w_go_recv;
  logic            w_wd_clr;
  logic            w_wd_en;
  logic            w_wd_tc;
  logic [WD_W-1:0] w_wd_limit;

  assign w_abort   = !bus.enable || (bus.cfg_mode != r_cfg);
  assign w_go_recv = bus.BD_flag && bus.PD_flag;

  // One watchdog serves both phases: it restarts on SYNC entry (cleared
  // while in ARM) and again on the SYNC->RECV hand-over.
  assign w_wd_en    = (r_state == STATE_SYNC) || (r_state == STATE_RECV);
  assign w_wd_clr   = !w_wd_en || ((r_state == STATE_SYNC) && w_go_recv);
  assign w_wd_limit = (r_state == STATE_RECV) ? c_rx_last : c_sync_last;

  rx_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_wd_clr),
    .i_en    (w_wd_en),
    .i_limit (w_wd_limit),
    .o_tc    (w_wd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= STATE_IDLE;
      r_cfg          <= MODE_NONE;
      r_mode_ctrl    <= MODE_NONE;
      r_dpkt_rst     <= 1'b1;
      r_clr_det      <= 1'b0;
      r_busy         <= 1'b0;
      r_err_pulse    <= 1'b0;
      r_flush_cnt    <= '0;
      r_frame_cnt    <= '0;
      r_sync_err_cnt <= '0;
      r_rx_err_cnt   <= '0;
    end else begin
      r_clr_det   <= 1'b0;
      r_err_pulse <= 1'b0;

      // Depacketizer controls follow the state register by one cycle.
      case (r_state)
        STATE_IDLE:  begin r_mode_ctrl <= MODE_NONE; r_dpkt_rst <= 1'b1; end
        STATE_PASS:  begin r_mode_ctrl <= r_cfg;     r_dpkt_rst <= 1'b0; end
        STATE_FLUSH: begin r_mode_ctrl <= MODE_MIX;  r_dpkt_rst <= 1'b1; end
        default:     begin r_mode_ctrl <= MODE_MIX;  r_dpkt_rst <= 1'b0; end
      endcase

      if (r_state != STATE_FLUSH) begin
        r_flush_cnt <= '0;
      end

      case (r_state)
        STATE_IDLE: begin
          if (bus.enable && is_pass_mode(bus.cfg_mode)) begin
            r_state <= STATE_PASS;
            r_cfg   <= bus.cfg_mode;
            r_busy  <= 1'b0;
          end else if (bus.enable && (bus.cfg_mode == MODE_MIX)) begin
            r_state   <= STATE_FLUSH;
            r_cfg     <= bus.cfg_mode;
            r_busy    <= 1'b1;
            r_clr_det <= 1'b1;
          end
        end
        STATE_PASS: begin
          if (w_abort) begin
            r_state <= STATE_IDLE;
            r_busy  <= 1'b0;
          end
        end
        STATE_ARM: begin
          if (w_abort) begin
            r_state <= STATE_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.SD_flag) begin
            r_state <= STATE_SYNC;
            r_busy  <= 1'b1;
          end
        end
        STATE_SYNC: begin
          if (w_abort) begin
            r_state <= STATE_IDLE;
            r_busy  <= 1'b0;
          end else if (w_go_recv) begin
            r_state <= STATE_RECV;
          end else if (!bus.SD_flag) begin
            r_state <= STATE_ARM;
            r_busy  <= 1'b0;
          end else if (w_wd_tc) begin
            r_state        <= STATE_FLUSH;
            r_clr_det      <= 1'b1;
            r_err_pulse    <= 1'b1;
            r_sync_err_cnt <= r_sync_err_cnt + c_cnt_one;
          end
        end
        STATE_RECV: begin
          if (w_abort) begin
            r_state <= STATE_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.pkt_last) begin
            r_state     <= STATE_FLUSH;
            r_clr_det   <= 1'b1;
            r_frame_cnt <= r_frame_cnt + c_cnt_one;
          end else if (w_wd_tc) begin
            r_state      <= STATE_FLUSH;
            r_clr_det    <= 1'b1;
            r_err_pulse  <= 1'b1;
            r_rx_err_cnt <= r_rx_err_cnt + c_cnt_one;
          end
        end
        STATE_FLUSH: begin
          if (w_abort) begin
            r_state <= STATE_IDLE;
            r_busy  <= 1'b0;
          end else if (r_flush_cnt == c_flush_last) begin
            r_state <= STATE_ARM;
            r_busy  <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt + c_flush_one;
          end
        end
        default: begin
          r_state <= STATE_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MODE_CTRL    = r_mode_ctrl;
  assign bus.dpkt_rst     = r_dpkt_rst;
  assign bus.clr_det      = r_clr_det;
  assign bus.busy         = r_busy;
  assign bus.state_o      = r_state;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.sync_err_cnt = r_sync_err_cnt;
  assign bus.rx_err_cnt   = r_rx_err_cnt;
  assign bus.err_pulse    = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_rx_frame_ctrl
// Brief  : Directed self-checking bench for the receive frame sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_rx_frame_ctrl;
  import rx_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rx_frame_ctrl_if #(.CNT_WIDTH(16)) bus ();

  rx_frame_ctrl #(
    .SYNC_TIMEOUT (16),
    .RX_TIMEOUT   (100),
    .FLUSH_CC     (4),
    .CNT_WIDTH    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_stay(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (bus.state_o == st && n < budget) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    int k = 0;
    while (bus.state_o != st && k < budget) begin
      k++;
      tick();
    end
    ok = (bus.state_o == st);
  endtask

  task automatic enter_recv();
    bus.SD_flag = 1'b1; tick();
    bus.PD_flag = 1'b1; bus.BD_flag = 1'b1; tick();
    bus.SD_flag = 1'b0; bus.PD_flag = 1'b0; bus.BD_flag = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.cfg_mode = 4'b0000; bus.SD_flag = 1'b0;
    bus.PD_flag = 1'b0; bus.BD_flag = 1'b0; bus.pkt_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
    n_cmp++; if (bus.MODE_CTRL !== 4'b0000 || bus.dpkt_rst !== 1'b1) begin n_bad++; $display("FAIL reset_ctrl: mode=%b rst=%b want 0000/1", bus.MODE_CTRL, bus.dpkt_rst); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.clr_det !== 1'b0 || bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_flags: busy=%b clr=%b err=%b want 0", bus.busy, bus.clr_det, bus.err_pulse); end
    n_cmp++; if (bus.frame_cnt !== 16'd0 || bus.sync_err_cnt !== 16'd0 || bus.rx_err_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: %0d %0d %0d want 0", bus.frame_cnt, bus.sync_err_cnt, bus.rx_err_cnt); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    int n; int nd; int nc;
    bus.cfg_mode = MODE_MIX; bus.enable = 1'b1; tick();
    n_cmp++; if (bus.state_o !== 3'd5 || bus.clr_det !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL frame_init_flush: state=%0d clr=%b busy=%b want 5/1/1", bus.state_o, bus.clr_det, bus.busy); end
    count_stay(3'd5, 20, n);
    n_cmp++; if (n !== 4 || bus.state_o !== 3'd2) begin n_bad++; $display("FAIL frame_init_flush_len: cycles=%0d state=%0d want 4/2", n, bus.state_o); end
    tick();
    n_cmp++; if (bus.MODE_CTRL !== 4'b0100 || bus.dpkt_rst !== 1'b0) begin n_bad++; $display("FAIL frame_arm_ctrl: mode=%b rst=%b want 0100/0", bus.MODE_CTRL, bus.dpkt_rst); end
    bus.SD_flag = 1'b1; tick();
    n_cmp++; if (bus.state_o !== 3'd3 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL frame_sync: state=%0d busy=%b want 3/1", bus.state_o, bus.busy); end
    repeat (9) tick();
    bus.PD_flag = 1'b1; bus.BD_flag = 1'b1; tick();
    n_cmp++; if (bus.state_o !== 3'd4) begin n_bad++; $display("FAIL frame_recv: state=%0d want 4", bus.state_o); end
    bus.SD_flag = 1'b0; bus.PD_flag = 1'b0; bus.BD_flag = 1'b0;
    repeat (49) tick();
    n_cmp++; if (bus.state_o !== 3'd4) begin n_bad++; $display("FAIL frame_recv_hold: state=%0d want 4", bus.state_o); end
    bus.pkt_last = 1'b1; tick(); bus.pkt_last = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd5 || bus.frame_cnt !== 16'd1 || bus.clr_det !== 1'b1 || bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL frame_done: state=%0d frames=%0d clr=%b err=%b want 5/1/1/0", bus.state_o, bus.frame_cnt, bus.clr_det, bus.err_pulse); end
    nd = 0; nc = 0;
    repeat (8) begin
      tick();
      if (bus.dpkt_rst) nd++;
      if (bus.clr_det) nc++;
    end
    n_cmp++; if (nd !== 4 || nc !== 0 || bus.state_o !== 3'd2) begin n_bad++; $display("FAIL frame_flush: rst_cycles=%0d extra_clr=%0d state=%0d want 4/0/2", nd, nc, bus.state_o); end
  endtask

  task automatic test_sync_timeout();
    int n; bit ok;
    bus.SD_flag = 1'b1; tick();
    count_stay(3'd3, 40, n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL sync_to_len: cycles=%0d want 16", n); end
    n_cmp++; if (bus.state_o !== 3'd5 || bus.sync_err_cnt !== 16'd1 || bus.err_pulse !== 1'b1 || bus.clr_det !== 1'b1) begin n_bad++; $display("FAIL sync_to: state=%0d serr=%0d err=%b clr=%b want 5/1/1/1", bus.state_o, bus.sync_err_cnt, bus.err_pulse, bus.clr_det); end
    bus.SD_flag = 1'b0; tick();
    n_cmp++; if (bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL sync_to_pulse: err=%b want 0", bus.err_pulse); end
    wait_state(3'd2, 10, ok);
    n_cmp++; if (!ok || bus.frame_cnt !== 16'd1) begin n_bad++; $display("FAIL sync_to_rearm: state=%0d frames=%0d want 2/1", bus.state_o, bus.frame_cnt); end
  endtask

  task automatic test_rx_timeout();
    int n; bit ok;
    enter_recv();
    count_stay(3'd4, 200, n);
    n_cmp++; if (n !== 100) begin n_bad++; $display("FAIL rx_to_len: cycles=%0d want 100", n); end
    n_cmp++; if (bus.state_o !== 3'd5 || bus.rx_err_cnt !== 16'd1 || bus.frame_cnt !== 16'd1 || bus.err_pulse !== 1'b1) begin n_bad++; $display("FAIL rx_to: state=%0d rerr=%0d frames=%0d err=%b want 5/1/1/1", bus.state_o, bus.rx_err_cnt, bus.frame_cnt, bus.err_pulse); end
    wait_state(3'd2, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rx_to_rearm: state=%0d want 2", bus.state_o); end
    enter_recv();
    repeat (99) tick();
    n_cmp++; if (bus.state_o !== 3'd4) begin n_bad++; $display("FAIL rx_last_edge_hold: state=%0d want 4", bus.state_o); end
    bus.pkt_last = 1'b1; tick(); bus.pkt_last = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd5 || bus.frame_cnt !== 16'd2 || bus.rx_err_cnt !== 16'd1 || bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL rx_last_edge: state=%0d frames=%0d rerr=%0d err=%b want 5/2/1/0", bus.state_o, bus.frame_cnt, bus.rx_err_cnt, bus.err_pulse); end
    wait_state(3'd2, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rx_last_rearm: state=%0d want 2", bus.state_o); end
  endtask

  task automatic test_sd_drop();
    bus.SD_flag = 1'b1; tick();
    repeat (5) tick();
    bus.SD_flag = 1'b0; tick();
    n_cmp++; if (bus.state_o !== 3'd2 || bus.sync_err_cnt !== 16'd1 || bus.err_pulse !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL sd_drop: state=%0d serr=%0d err=%b busy=%b want 2/1/0/0", bus.state_o, bus.sync_err_cnt, bus.err_pulse, bus.busy); end
  endtask

  task automatic test_enable_drop();
    enter_recv();
    repeat (10) tick();
    bus.enable = 1'b0; tick();
    n_cmp++; if (bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL en_drop_state: state=%0d busy=%b want 0/0", bus.state_o, bus.busy); end
    n_cmp++; if (bus.frame_cnt !== 16'd2 || bus.rx_err_cnt !== 16'd1 || bus.sync_err_cnt !== 16'd1) begin n_bad++; $display("FAIL en_drop_cnt: %0d %0d %0d want 2/1/1", bus.frame_cnt, bus.rx_err_cnt, bus.sync_err_cnt); end
    tick();
    n_cmp++; if (bus.MODE_CTRL !== 4'b0000 || bus.dpkt_rst !== 1'b1) begin n_bad++; $display("FAIL en_drop_ctrl: mode=%b rst=%b want 0000/1", bus.MODE_CTRL, bus.dpkt_rst); end
  endtask

  task automatic test_pass();
    int n;
    bus.enable = 1'b1; bus.cfg_mode = 4'b0011;
    repeat (3) tick();
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL pass_bad_mode: state=%0d want 0", bus.state_o); end
    bus.cfg_mode = MODE_QPSK; tick();
    n_cmp++; if (bus.state_o !== 3'd1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL pass_state: state=%0d busy=%b want 1/0", bus.state_o, bus.busy); end
    tick();
    n_cmp++; if (bus.MODE_CTRL !== 4'b0010 || bus.dpkt_rst !== 1'b0) begin n_bad++; $display("FAIL pass_ctrl: mode=%b rst=%b want 0010/0", bus.MODE_CTRL, bus.dpkt_rst); end
    bus.cfg_mode = MODE_MIX; tick();
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL pass_exit: state=%0d want 0", bus.state_o); end
    tick();
    count_stay(3'd5, 20, n);
    n_cmp++; if (n !== 4 || bus.state_o !== 3'd2) begin n_bad++; $display("FAIL pass_to_mix: flush=%0d state=%0d want 4/2", n, bus.state_o); end
  endtask

  task automatic test_async_reset();
    bit ok;
    enter_recv();
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 3'd0 || bus.dpkt_rst !== 1'b1 || bus.MODE_CTRL !== 4'b0000 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_ctrl: state=%0d rst=%b mode=%b busy=%b want 0/1/0000/0", bus.state_o, bus.dpkt_rst, bus.MODE_CTRL, bus.busy); end
    n_cmp++; if (bus.frame_cnt !== 16'd0 || bus.sync_err_cnt !== 16'd0 || bus.rx_err_cnt !== 16'd0) begin n_bad++; $display("FAIL arst_cnt: %0d %0d %0d want 0", bus.frame_cnt, bus.sync_err_cnt, bus.rx_err_cnt); end
    #3 rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.state_o !== 3'd5) begin n_bad++; $display("FAIL arst_restart: state=%0d want 5", bus.state_o); end
    wait_state(3'd2, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL arst_rearm: state=%0d want 2", bus.state_o); end
    bus.SD_flag = 1'b1; tick();
    repeat (3) tick();
    bus.PD_flag = 1'b1; bus.BD_flag = 1'b1; tick();
    bus.SD_flag = 1'b0; bus.PD_flag = 1'b0; bus.BD_flag = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd4) begin n_bad++; $display("FAIL arst_recv: state=%0d want 4", bus.state_o); end
    repeat (20) tick();
    bus.pkt_last = 1'b1; tick(); bus.pkt_last = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd5 || bus.frame_cnt !== 16'd1 || bus.sync_err_cnt !== 16'd0 || bus.rx_err_cnt !== 16'd0) begin n_bad++; $display("FAIL arst_frame: state=%0d frames=%0d serr=%0d rerr=%0d want 5/1/0/0", bus.state_o, bus.frame_cnt, bus.sync_err_cnt, bus.rx_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_sync_timeout();
    test_rx_timeout();
    test_sd_drop();
    test_enable_drop();
    test_pass();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
